// File: rtl/shift_request_feeder_pkg.sv
// Shared constants for the shift request feeder.
//   NBITS_DEF   : default operand width (barrelShifter nBits)
//   NSHIFTS_DEF : default shift-control width (barrelShifter nShifts)
//   clog2()     : pointer width for a FIFO of a given depth
package shift_request_feeder_pkg;

  localparam int unsigned NBITS_DEF   = 8;
  localparam int unsigned NSHIFTS_DEF = 3;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_request_feeder_fifo.sv
// DEPTH x WIDTH request FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   flush      : synchronous clear of pointers/count; storage is kept
//   push/wdata : write one entry (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   rdata      : head entry, straight from storage
//   count      : occupancy, 0..DEPTH
module shift_req_fifo
  import shift_request_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/shift_request_feeder.sv
// Feeder and result register around an external combinational barrelShifter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous clear of FIFO and output register
//   in_valid/in_ready   : producer handshake for {in_data, in_shift}
//   bs_in/bs_shift      : FIFO head presented to the shifter
//   bs_out              : shifter result
//   out_valid/out_ready : consumer handshake for {out_data, out_shift}
//   count               : FIFO occupancy
module shift_request_feeder
  import shift_request_feeder_pkg::*;
#(
  parameter int unsigned NBITS   = NBITS_DEF,
  parameter int unsigned NSHIFTS = NSHIFTS_DEF,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NBITS-1:0]      in_data,
  input  logic [NSHIFTS-1:0]    in_shift,
  output logic [NBITS-1:0]      bs_in,
  output logic [NSHIFTS-1:0]    bs_shift,
  input  logic [NBITS-1:0]      bs_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBITS-1:0]      out_data,
  output logic [NSHIFTS-1:0]    out_shift,
  output logic [clog2(DEPTH):0] count
);

  localparam int unsigned CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic                 push, load;
  logic [CW-1:0]        fifo_count;
  logic [NBITS+NSHIFTS-1:0] head;
  logic                 out_valid_q;
  logic [NBITS-1:0]     out_data_q;
  logic [NSHIFTS-1:0]   out_shift_q;

  // in_ready looks only at registered occupancy: no full-FIFO pass-through.
  assign in_ready = (fifo_count < DEPTH_C);
  assign push     = in_valid && in_ready && !flush;
  assign load     = (fifo_count != '0) && (!out_valid_q || out_ready) && !flush;

  shift_req_fifo #(
    .WIDTH (NBITS + NSHIFTS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata ({in_shift, in_data}),
    .pop   (load),
    .rdata (head),
    .count (fifo_count)
  );

  assign {bs_shift, bs_in} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_shift_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bs_out;
      out_shift_q <= bs_shift;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shift = out_shift_q;
  assign count     = fifo_count;

endmodule

// File: doc/shift_request_feeder.md
Name: shift_request_feeder

Overview:
- Upstream feeder and downstream result register for the combinational barrelShifter datapath.
- Buffers {data, shift} requests from a valid/ready producer in a small FIFO and presents the FIFO head to a barrelShifter instance.
- Registers the shifter result with a valid/ready consumer interface, so the combinational shifter sits between two registered, back-pressurable boundaries.

Parameters:
- NBITS, 8, data width; matches barrelShifter nBits.
- NSHIFTS, 3, shift-control width; matches barrelShifter nShifts.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of FIFO and output register.
- in_valid  input  1  producer request valid.
- in_ready  output  1  FIFO can accept.
- in_data  input  NBITS  operand.
- in_shift  input  NSHIFTS  shift control.
- bs_in  output  NBITS  to barrelShifter in.
- bs_shift  output  NSHIFTS  to barrelShifter shift.
- bs_out  input  NBITS  from barrelShifter out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_data  output  NBITS  registered shifter result.
- out_shift  output  NSHIFTS  shift control echoed with the result.
- count  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, out_valid=0, out_data=0, out_shift=0.
  - Read and write pointers = 0; storage cleared to 0, so bs_in=0 and bs_shift=0.
  - in_ready=1 once rst_n is high.
- Clock and reset: one clock domain; reset is asynchronous assert, active-low (rst_n). Deassertion is assumed synchronised externally.
- Push: push = in_valid && in_ready. in_ready = (count < DEPTH), combinational from registered count only; it never depends on out_ready, so there is no pass-through when full.
- Head presentation: bs_in and bs_shift are driven directly from the storage entry at the read pointer (registered storage, no comb path from in_*). When empty they hold the stale entry; consumers ignore them.
- Output load:
  - load = (count != 0) && (!out_valid || out_ready).
  - On load: out_data <= bs_out, out_shift <= bs_shift, out_valid <= 1, pop head.
  - If out_valid && out_ready && count==0: out_valid <= 0 and out_data holds.
- Latency: a request accepted at edge N gives out_valid=1 after edge N+1 when FIFO and output register are empty.
- Throughput: 1 result per cycle with out_ready held high.
- Simultaneous push and pop: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- Full: count==DEPTH, in_ready=0. A pop in that cycle raises in_ready on the next cycle, not the same cycle.
- Empty with out_ready=0: out_valid and out_data hold indefinitely; the registered output stays stable while stalled.
- flush:
  - Has priority over push and load: count=0, pointers=0, out_valid=0.
  - in_valid is ignored during the flush cycle.
  - Storage contents are not cleared.
- Reset mid-stream: all in-flight requests are lost; no partial output.

Decomposition:
- Shared include: default width constants (NBITS=8, NSHIFTS=3) and the FIFO pointer-width function (clog2).
- One natural sub-module: shift_req_fifo, a parameterised DEPTH x (NBITS+NSHIFTS) FIFO with count output.
- Top level holds the output register and handshake logic. The barrelShifter instance stays outside this block and is connected by the integrator via bs_*.
- Bench instantiates barrelShifter as the golden datapath and scoreboards against it.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> out_valid=0, count=0, in_ready=1, out_data=0; assert rst_n mid-burst -> outputs return to reset values asynchronously.
- Single request: in_data=0x01, in_shift=3, out_ready=1 -> out_valid at edge N+1; out_data equals barrelShifter(0x01,3); out_shift=3; count returns to 0.
- Stream: 16 back-to-back random requests, out_ready=1 -> 16 results in order, one per cycle, in_ready never drops, each result matches barrelShifter(in,shift).
- Full/backpressure:
  - out_ready=0, push 5 requests -> 1 lands in the output register, count=4, in_ready=0; the 6th request is held by the producer.
  - Raise out_ready -> in-order drain, in_ready=1 one cycle after the first pop.
- Wrap and simultaneous push/pop: random in_valid and out_ready (50%) for 200 cycles -> scoreboard exact order and values; count stays in 0..4; no loss or duplication.
- Flush: with count=3 and out_valid=1, pulse flush -> next cycle count=0, out_valid=0; a following request 0xA5 with shift 1 yields only barrelShifter(0xA5,1).
